cga_text_fetch: RTL and testbench

//  CGA 80/40-column text-mode fetch/shift stage on the display side of the dual-port video RAM.
//  - Reads character and attribute bytes through VRAM port B.
//  - Looks up glyph rows in an external 8x8 font ROM.
//  - Serialises glyph rows into 4-bit colour indices for the palette/DAC stage.
//  - Prefetches one character cell ahead of the pixel shifter.

---
 rtl/cga_pkg.sv | 35 +++
 rtl/cga_attr_shift.sv | 116 +++++++++++
 rtl/cga_text_fetch.sv | 200 ++++++++++++++++++++
 tb/tb_cga_text_fetch.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cga_pkg
// Desc     : Shared fetch-state encoding, cell geometry and attribute helpers
//            for the CGA text fetch/shift path.
// Revision : 1.0 - initial release
// ============================================================================
package cga_pkg;

    localparam int CGA_CELL_PX = 8;
    localparam int CGA_FONT_H  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_CHR = 3'd1,
        ST_RD_ATR = 3'd2,
        ST_RD_FNT = 3'd3,
        ST_LOAD   = 3'd4
    } fetch_state_t;

    function automatic logic [3:0] attr_fg(input logic [7:0] attr);
        return attr[3:0];
    endfunction

    function automatic logic [2:0] attr_bg_rgb(input logic [7:0] attr);
        return attr[6:4];
    endfunction

    // Blink flag or background intensity, depending on build
    function automatic logic attr_bit7(input logic [7:0] attr);
        return attr[7];
    endfunction

endpackage
`default_nettype wire

// File: rtl/cga_attr_shift.sv
`default_nettype none
// ============================================================================
// Module   : cga_attr_shift
// Desc     : 8-pixel glyph shifter with attribute-to-colour mux; optional
//            blink handling when CGA_BLINK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module cga_attr_shift
    import cga_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic       de,
    input  logic       blank,
`ifdef CGA_BLINK_EN
    input  logic       frame_start,
`endif
    input  logic       load_valid,
    input  logic [7:0] load_glyph,
    input  logic [7:0] load_attr,
    output logic       load_ack,
    output logic [3:0] pix_color,
    output logic       pix_valid,
    output logic       underrun
);

    localparam int c_PH_W = $clog2(CGA_CELL_PX);

    logic [c_PH_W-1:0] r_phase;
    logic [7:0]        r_shift;
    logic [7:0]        r_attr;
    logic [3:0]        r_color;
    logic              r_valid;
    logic              r_underrun;

    logic              w_phase0;
    logic              w_active;
    logic [7:0]        w_glyph;
    logic [7:0]        w_attr;
    logic [3:0]        w_bg;
    logic              w_fg_on;
    logic [3:0]        w_color;

    assign w_phase0 = (r_phase == '0);
    assign w_active = ce_pix && de && !blank;
    assign load_ack = w_active && w_phase0 && load_valid;

    // At phase 0 the new cell is taken straight from the pending buffer so the
    // first pixel of the cell leaves on the same ce_pix as the load.
    always_comb begin
        w_glyph = r_shift;
        w_attr  = r_attr;
        if (w_phase0) begin
            w_glyph = load_valid ? load_glyph : 8'h00;
            w_attr  = load_valid ? load_attr  : 8'h00;
        end
    end

`ifdef CGA_BLINK_EN
    logic [3:0] r_frame_cnt;
    logic       r_blink_phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt   <= 4'd0;
            r_blink_phase <= 1'b0;
        end else if (frame_start) begin
            r_frame_cnt <= r_frame_cnt + 4'd1;
            if (r_frame_cnt == 4'd15) begin
                r_blink_phase <= ~r_blink_phase;
            end
        end
    end

    assign w_bg    = {1'b0, attr_bg_rgb(w_attr)};
    assign w_fg_on = w_glyph[7] && !(attr_bit7(w_attr) && r_blink_phase);
`else
    assign w_bg    = {attr_bit7(w_attr), attr_bg_rgb(w_attr)};
    assign w_fg_on = w_glyph[7];
`endif

    assign w_color = w_fg_on ? attr_fg(w_attr) : w_bg;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase    <= '0;
            r_shift    <= 8'h00;
            r_attr     <= 8'h00;
            r_color    <= 4'h0;
            r_valid    <= 1'b0;
            r_underrun <= 1'b0;
        end else if (ce_pix) begin
            if (!w_active) begin
                r_phase <= '0;
                r_color <= 4'h0;
                r_valid <= 1'b0;
            end else begin
                r_phase <= r_phase + c_PH_W'(1);
                r_shift <= {w_glyph[6:0], 1'b0};
                r_attr  <= w_attr;
                r_color <= w_color;
                r_valid <= 1'b1;
                if (w_phase0 && !load_valid) begin
                    r_underrun <= 1'b1;
                end
            end
        end
    end

    assign pix_color = r_color;
    assign pix_valid = r_valid;
    assign underrun  = r_underrun;

endmodule
`default_nettype wire

// File: rtl/cga_text_fetch.sv
`default_nettype none
// ============================================================================
// Module   : cga_text_fetch
// Desc     : CGA text-mode fetch FSM, col/row/scan sequencing and one-cell
//            prefetch feeding the glyph shifter. Optional macro: CGA_BLINK_EN.
//            VRAM_AW is expected in the range 2..14.
// Revision : 1.0 - initial release
// ============================================================================
module cga_text_fetch
    import cga_pkg::*;
#(
    parameter int COLS    = 80,
    parameter int ROWS    = 25,
    parameter int VRAM_AW = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_pix,
    input  logic        frame_start,
    input  logic        line_start,
    input  logic        de,
    input  logic [13:0] start_addr,
    output logic        vram_en,
    output logic [14:0] vram_addr,
    input  logic [7:0]  vram_dout,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [3:0]  pix_color,
    output logic        pix_valid,
    output logic        underrun
);

    localparam int c_CELL_W = VRAM_AW - 1;
    localparam int c_COL_W  = $clog2(COLS + 1);
    localparam int c_ROW_W  = $clog2(ROWS + 1);
    localparam int c_SCAN_W = $clog2(CGA_FONT_H);

    localparam logic [c_COL_W-1:0]  c_COLS       = c_COL_W'(COLS);
    localparam logic [c_ROW_W-1:0]  c_ROWS       = c_ROW_W'(ROWS);
    localparam logic [c_CELL_W-1:0] c_ROW_STRIDE = c_CELL_W'(COLS);
    localparam logic [c_SCAN_W-1:0] c_SCAN_LAST  = c_SCAN_W'(CGA_FONT_H - 1);

    fetch_state_t          r_state;
    fetch_state_t          w_state_nxt;
    logic [c_COL_W-1:0]    r_col;
    logic [c_ROW_W-1:0]    r_row;
    logic [c_SCAN_W-1:0]   r_scan;
    logic [c_CELL_W-1:0]   r_row_base;
    logic                  r_first_line;
    logic                  r_armed;
    logic [10:0]           r_font_addr;
    logic [7:0]            r_attr;
    logic                  r_pend_valid;
    logic [7:0]            r_pend_glyph;
    logic [7:0]            r_pend_attr;

    logic [c_ROW_W-1:0]    w_row;
    logic [c_SCAN_W-1:0]   w_scan;
    logic [c_CELL_W-1:0]   w_row_base;
    logic                  w_first;
    logic                  w_armed;
    logic                  w_abort;
    logic [c_CELL_W-1:0]   w_cell;
    logic [VRAM_AW-1:0]    w_byte_addr;
    logic                  w_vram_en;
    logic                  w_load_ack;

    assign w_abort = frame_start || line_start;
    assign w_cell  = r_row_base + c_CELL_W'(r_col);

    // Frame handling is applied before line handling so a coincident pair
    // lands on row 0 / scan 0 of the new frame.
    always_comb begin
        w_row      = r_row;
        w_scan     = r_scan;
        w_row_base = r_row_base;
        w_first    = r_first_line;
        w_armed    = r_armed;
        if (frame_start) begin
            w_row      = '0;
            w_scan     = c_SCAN_LAST;
            w_row_base = c_CELL_W'(start_addr);
            w_first    = 1'b1;
            w_armed    = 1'b0;
        end
        if (line_start) begin
            if (w_first) begin
                w_scan  = '0;
                w_first = 1'b0;
            end else begin
                w_scan = w_scan + c_SCAN_W'(1);
                if (w_scan == '0 && w_row < c_ROWS) begin
                    w_row      = w_row + c_ROW_W'(1);
                    w_row_base = w_row_base + c_ROW_STRIDE;
                end
            end
            w_armed = (w_row < c_ROWS);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_vram_en   = 1'b0;
        w_byte_addr = '0;
        case (r_state)
            ST_IDLE: begin
                if (!r_pend_valid && (r_col < c_COLS) && r_armed) begin
                    w_state_nxt = ST_RD_CHR;
                end
            end
            ST_RD_CHR: begin
                w_vram_en   = 1'b1;
                w_byte_addr = {w_cell, 1'b0};
                w_state_nxt = ST_RD_ATR;
            end
            ST_RD_ATR: begin
                w_vram_en   = 1'b1;
                w_byte_addr = {w_cell, 1'b1};
                w_state_nxt = ST_RD_FNT;
            end
            ST_RD_FNT: w_state_nxt = ST_LOAD;
            ST_LOAD:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_scan       <= '0;
            r_row_base   <= '0;
            r_first_line <= 1'b0;
            r_armed      <= 1'b0;
            r_font_addr  <= 11'd0;
            r_attr       <= 8'h00;
            r_pend_valid <= 1'b0;
            r_pend_glyph <= 8'h00;
            r_pend_attr  <= 8'h00;
        end else begin
            r_state      <= w_state_nxt;
            r_row        <= w_row;
            r_scan       <= w_scan;
            r_row_base   <= w_row_base;
            r_first_line <= w_first;
            r_armed      <= w_armed;

            if (line_start) begin
                r_col <= '0;
            end else if (r_state == ST_LOAD && !frame_start) begin
                r_col <= r_col + c_COL_W'(1);
            end

            if (r_state == ST_RD_ATR && !w_abort) begin
                r_font_addr <= {vram_dout, r_scan};
            end
            if (r_state == ST_RD_FNT) begin
                r_attr <= vram_dout;
            end

            if (w_abort) begin
                r_pend_valid <= 1'b0;
            end else if (r_state == ST_LOAD) begin
                r_pend_valid <= 1'b1;
                r_pend_glyph <= font_data;
                r_pend_attr  <= r_attr;
            end else if (w_load_ack) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    assign vram_en   = w_vram_en;
    assign vram_addr = 15'(w_byte_addr);
    assign font_addr = r_font_addr;

    cga_attr_shift u_shift (
        .clk         (clk),
        .reset       (reset),
        .ce_pix      (ce_pix),
        .de          (de),
        .blank       (line_start),
`ifdef CGA_BLINK_EN
        .frame_start (frame_start),
`endif
        .load_valid  (r_pend_valid),
        .load_glyph  (r_pend_glyph),
        .load_attr   (r_pend_attr),
        .load_ack    (w_load_ack),
        .pix_color   (pix_color),
        .pix_valid   (pix_valid),
        .underrun    (underrun)
    );

endmodule
`default_nettype wire

// File: tb/tb_cga_text_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_cga_text_fetch
// Desc     : Directed self-checking bench for cga_text_fetch with behavioural
//            VRAM and font ROM models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cga_text_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce_pix;
    logic        frame_start;
    logic        line_start;
    logic        de;
    logic [13:0] start_addr;
    logic        vram_en;
    logic [14:0] vram_addr;
    logic [7:0]  vram_dout;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic [3:0]  pix_color;
    logic        pix_valid;
    logic        underrun;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  vmem [0:16383];
    logic [7:0]  fmem [0:2047];
    logic [14:0] rd_log [$];

    cga_text_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .ce_pix      (ce_pix),
        .frame_start (frame_start),
        .line_start  (line_start),
        .de          (de),
        .start_addr  (start_addr),
        .vram_en     (vram_en),
        .vram_addr   (vram_addr),
        .vram_dout   (vram_dout),
        .font_addr   (font_addr),
        .font_data   (font_data),
        .pix_color   (pix_color),
        .pix_valid   (pix_valid),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vram_en) vram_dout <= vmem[vram_addr[13:0]];
        font_data <= fmem[font_addr];
    end

    always @(posedge clk) begin
        if (!reset && vram_en) rd_log.push_back(vram_addr);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1; step(1); frame_start = 1'b0;
    endtask

    task automatic pulse_line();
        line_start = 1'b1; step(1); line_start = 1'b0;
    endtask

    task automatic pix6(input logic d);
        de = d; ce_pix = 1'b1; step(1); ce_pix = 1'b0; step(5);
    endtask

    task automatic wait_reads(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (rd_log.size() < n && k < budget) begin
            step(1);
            k++;
        end
        n_checks++;
        if (rd_log.size() < n) begin
            n_fail++;
            $display("FAIL %s: got %0d reads, required %0d", tag, rd_log.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; ce_pix = 1'b0; frame_start = 1'b0; line_start = 1'b0;
        de = 1'b0; start_addr = 14'd0;
        step(3);
        n_checks++;
        if ({vram_en, vram_addr, font_addr, pix_color, pix_valid, underrun} !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0",
                     {vram_en, vram_addr, font_addr, pix_color, pix_valid, underrun});
        end
        reset = 1'b0;
        step(5);
        n_checks++;
        if (vram_en !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: vram_en %b required 0", vram_en);
        end
    endtask

    task automatic test_addr_seq();
        start_addr = 14'd0;
        rd_log.delete();
        pulse_frame();
        pulse_line();
        wait_reads(2, 20, "addr_seq_first");
        n_checks++;
        if (rd_log[0] !== 15'h0000 || rd_log[1] !== 15'h0001) begin
            n_fail++;
            $display("FAIL addr_seq_first: got %h %h required 0000 0001", rd_log[0], rd_log[1]);
        end
        step(20);
        n_checks++;
        if (rd_log.size() != 2) begin
            n_fail++;
            $display("FAIL prefetch_hold: got %0d reads required 2", rd_log.size());
        end
        n_checks++;
        if (font_addr !== 11'h208) begin
            n_fail++;
            $display("FAIL font_addr_cell0: got %h required 208", font_addr);
        end
    endtask

    task automatic test_pixels();
        logic [3:0] exp_c [8];
        exp_c = '{4'hE, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'hE};
        for (int i = 0; i < 8; i++) begin
            pix6(1'b1);
            n_checks++;
            if (pix_color !== exp_c[i] || pix_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL pixel[%0d]: got color %h valid %b required %h 1",
                         i, pix_color, pix_valid, exp_c[i]);
            end
        end
        pix6(1'b0);
        n_checks++;
        if (pix_color !== 4'h0 || pix_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pixel_de_low: got color %h valid %b required 0 0", pix_color, pix_valid);
        end
        wait_reads(4, 10, "addr_seq_second");
        n_checks++;
        if (rd_log[2] !== 15'h0002 || rd_log[3] !== 15'h0003) begin
            n_fail++;
            $display("FAIL addr_seq_second: got %h %h required 0002 0003", rd_log[2], rd_log[3]);
        end
    endtask

    task automatic test_wrap();
        start_addr = 14'h1FFF;
        rd_log.delete();
        frame_start = 1'b1; line_start = 1'b1; step(1);
        frame_start = 1'b0; line_start = 1'b0;
        wait_reads(2, 20, "wrap_col0");
        n_checks++;
        if (rd_log[0] !== 15'h3FFE || rd_log[1] !== 15'h3FFF) begin
            n_fail++;
            $display("FAIL wrap_col0: got %h %h required 3ffe 3fff", rd_log[0], rd_log[1]);
        end
        step(5);
        pix6(1'b1);
        wait_reads(4, 20, "wrap_col1");
        n_checks++;
        if (rd_log[2] !== 15'h0000 || rd_log[3] !== 15'h0001) begin
            n_fail++;
            $display("FAIL wrap_col1: got %h %h required 0000 0001", rd_log[2], rd_log[3]);
        end
        pix6(1'b0);
    endtask

    task automatic test_scan_row();
        start_addr = 14'd0;
        pulse_frame();
        pulse_line();
        step(10);
        line_start = 1'b1; ce_pix = 1'b1; de = 1'b1; step(1);
        line_start = 1'b0; ce_pix = 1'b0; de = 1'b0;
        n_checks++;
        if (pix_valid !== 1'b0 || pix_color !== 4'h0) begin
            n_fail++;
            $display("FAIL blank_on_line_start: got color %h valid %b required 0 0", pix_color, pix_valid);
        end
        step(10);
        n_checks++;
        if (font_addr !== 11'h209) begin
            n_fail++;
            $display("FAIL font_addr_scan1: got %h required 209", font_addr);
        end
        for (int i = 0; i < 6; i++) begin
            pulse_line();
            step(9);
        end
        rd_log.delete();
        pulse_line();
        wait_reads(1, 20, "row1_addr");
        n_checks++;
        if (rd_log[0] !== 15'h00A0) begin
            n_fail++;
            $display("FAIL row1_addr: got %h required 00a0", rd_log[0]);
        end
        step(5);
        n_checks++;
        if (font_addr !== 11'h500) begin
            n_fail++;
            $display("FAIL font_addr_row1: got %h required 500", font_addr);
        end
    endtask

    task automatic test_rows_end();
        start_addr = 14'd0;
        pulse_frame();
        for (int k = 1; k <= 199; k++) begin
            pulse_line();
            step(8);
        end
        rd_log.delete();
        pulse_line();
        wait_reads(1, 20, "row24_addr");
        n_checks++;
        if (rd_log[0] !== 15'h0F00) begin
            n_fail++;
            $display("FAIL row24_addr: got %h required 0f00", rd_log[0]);
        end
        step(8);
        rd_log.delete();
        pulse_line();
        step(20);
        n_checks++;
        if (rd_log.size() != 0) begin
            n_fail++;
            $display("FAIL row25_no_reads: got %0d reads required 0", rd_log.size());
        end
    endtask

    task automatic test_col_end();
        start_addr = 14'd0;
        pulse_frame();
        rd_log.delete();
        pulse_line();
        step(10);
        for (int i = 0; i < 80 * 8; i++) pix6(1'b1);
        n_checks++;
        if (rd_log.size() != 160 || rd_log[159] !== 15'd159) begin
            n_fail++;
            $display("FAIL col_end_reads: got %0d reads last %h required 160 009f",
                     rd_log.size(), rd_log[159]);
        end
        n_checks++;
        if (underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL no_underrun_in_line: got %b required 0", underrun);
        end
        pix6(1'b1);
        n_checks++;
        if (underrun !== 1'b1 || pix_valid !== 1'b1 || pix_color !== 4'h0 || rd_log.size() != 160) begin
            n_fail++;
            $display("FAIL col_end_underrun: got underrun %b valid %b color %h reads %0d required 1 1 0 160",
                     underrun, pix_valid, pix_color, rd_log.size());
        end
        pix6(1'b0);
    endtask

    task automatic test_reset_midfetch();
        int k;
        start_addr = 14'd0;
        pulse_frame();
        pulse_line();
        k = 0;
        while (!(vram_en === 1'b1 && vram_addr[0] === 1'b1) && k < 10) begin
            step(1);
            k++;
        end
        n_checks++;
        if (k >= 10) begin
            n_fail++;
            $display("FAIL reach_rd_atr: got no attribute read within %0d clk", k);
        end
        reset = 1'b1;
        step(1);
        n_checks++;
        if ({vram_en, vram_addr, font_addr, pix_color, pix_valid, underrun} !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_midfetch: got %h required 0",
                     {vram_en, vram_addr, font_addr, pix_color, pix_valid, underrun});
        end
        reset = 1'b0;
        step(2);
    endtask

    task automatic test_underrun_fast();
        start_addr = 14'd0;
        pulse_frame();
        pulse_line();
        for (int i = 0; i < 8; i++) begin
            de = 1'b1; ce_pix = 1'b1; step(1); ce_pix = 1'b0;
            n_checks++;
            if (pix_color !== 4'h0 || pix_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL underrun_pixel[%0d]: got color %h valid %b required 0 1", i, pix_color, pix_valid);
            end
            step(2);
        end
        n_checks++;
        if (underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL underrun_flag: got %b required 1", underrun);
        end
        pix6(1'b0);
    endtask

`ifdef CGA_BLINK_EN
    task automatic test_blink();
        logic [3:0] exp_c;
        vmem[0] = 8'h42; vmem[1] = 8'h8F; fmem[{8'h42, 3'd0}] = 8'hFF;
        start_addr = 14'd0;
        reset = 1'b1; step(2); reset = 1'b0; step(2);
        for (int f = 1; f <= 32; f++) begin
            pulse_frame();
            pulse_line();
            step(10);
            pix6(1'b1);
            exp_c = (f >= 16 && f <= 31) ? 4'h0 : 4'hF;
            if (f == 1 || f == 15 || f == 16 || f == 31 || f == 32) begin
                n_checks++;
                if (pix_color !== exp_c) begin
                    n_fail++;
                    $display("FAIL blink_frame%0d: got %h required %h", f, pix_color, exp_c);
                end
            end
            pix6(1'b0);
        end
    endtask
`else
    task automatic test_intensity();
        vmem[0] = 8'h43; vmem[1] = 8'hF0; fmem[{8'h43, 3'd0}] = 8'h00;
        start_addr = 14'd0;
        pulse_frame();
        pulse_line();
        step(10);
        pix6(1'b1);
        n_checks++;
        if (pix_color !== 4'hF || pix_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bg_intensity: got color %h valid %b required f 1", pix_color, pix_valid);
        end
        pix6(1'b0);
    endtask
`endif

    initial begin
        for (int i = 0; i < 16384; i++) vmem[i] = i[7:0];
        for (int i = 0; i < 2048; i++) fmem[i] = 8'h00;
        vmem[0] = 8'h41;
        vmem[1] = 8'h1E;
        fmem[{8'h41, 3'd0}] = 8'h81;

        test_reset();
        test_addr_seq();
        test_pixels();
        test_wrap();
        test_scan_row();
        test_rows_end();
        test_col_end();
        test_reset_midfetch();
        test_underrun_fast();
`ifdef CGA_BLINK_EN
        test_blink();
`else
        test_intensity();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
